mdu_iter: RTL
=============

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; legal values are even and >= 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request a new operation.
REQ-005 SHALL have port: op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have port: a  input  WIDTH  dividend or multiplicand.
REQ-007 SHALL have port: b  input  WIDTH  divisor or multiplier.
REQ-008 SHALL have port: cancel  input  1  pipeline flush; abort any operation in flight.
REQ-009 SHALL have port: busy  output  1  operation in progress; start is ignored while high.
REQ-010 SHALL have port: done  output  1  single-cycle pulse; hi and lo are valid.
REQ-011 SHALL have port: hi  output  WIDTH  product upper half, or remainder.
REQ-012 SHALL have port: lo  output  WIDTH  product lower half, or quotient.
REQ-013 SHALL have port: dbz  output  1  divide-by-zero flag; valid together with done.

Function
REQ-014 SHALL implement an FSM with states IDLE, MUL, DIV, FIN.
- start is accepted only in IDLE or FIN.
- Acceptance latches a, b and op.
- Next state: MUL for op 0/1, DIV for op 2/3.
REQ-015 SHALL operate on operand magnitudes for signed ops, then fix the sign of the results.
- Product sign = a[W-1]^b[W-1].
- Quotient sign = a[W-1]^b[W-1].
- Remainder sign = sign of a.
REQ-016 SHALL multiply by iterative shift-add, one multiplier bit per cycle, over exactly WIDTH cycles in MUL.
REQ-017 SHALL divide by iterative restoring division, one quotient bit per cycle, over exactly WIDTH cycles in DIV.
REQ-018 SHALL set timing as follows, with start accepted in cycle 0:
- busy is high in cycles 1..WIDTH.
- The FSM is in FIN in cycle WIDTH+1: done=1, busy=0.
REQ-019 SHALL hold hi, lo and dbz stable from done until the next done; FIN returns to IDLE unless start is accepted in that cycle.
REQ-020 SHALL handle b==0 with DIV/DIVU as follows:
- Skip the iteration and enter FIN in cycle 1.
- Results: dbz=1, hi=a, lo=all ones.
REQ-021 SHALL return quotient 2^(W-1) and remainder 0 for DIV of the most-negative value by -1; no trap, dbz=0.
REQ-022 SHALL, on cancel in any state:
- Go to IDLE on the next edge.
- Suppress done.
- Leave hi, lo and dbz unchanged.
- When cancel and start coincide, cancel wins and start is dropped.
REQ-023 SHALL clear dbz on every accepted start.

Reset
REQ-024 SHALL on rst_n low, immediately and asynchronously set: state=IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, and all iteration registers 0.
REQ-025 SHALL, when reset is asserted mid-operation, discard the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-026 SHALL honour the macro MDU_FAST_MUL_EN.
- When defined: MULT/MULTU compute the product combinationally, enter FIN in cycle 1, and busy never rises for multiplies.
- When undefined: the iterative WIDTH-cycle multiply of REQ-016 is used.
- Division timing is identical in both builds.

Structure
REQ-027 SHALL take the op encoding enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the state enum from the shared package mdu_pkg.
REQ-028 SHALL place the restoring-division single step (partial remainder, divisor -> next remainder, quotient bit) in sub-module mdu_div_step, instantiated once.

Verification (WIDTH=32)
REQ-029 SHALL check MULT a=0xFFFFFFFD, b=5 -> done in cycle 33 (iterative build), hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-030 SHALL check MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; with MDU_FAST_MUL_EN, done in cycle 1.
REQ-031 SHALL check DIVU 100/7 -> lo=14, hi=2; then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, with the second start issued in the FIN cycle of the first.
REQ-032 SHALL check DIV a=0x12345678, b=0 -> done in cycle 1, dbz=1, hi=0x12345678, lo=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-033 SHALL check start DIVU, then cancel in cycle 10 -> no done, busy=0 from cycle 11, hi/lo keep prior values; a new start in cycle 11 completes correctly.
REQ-034 SHALL check rst_n pulsed low mid-DIV between clock edges -> outputs zero immediately, no done, FSM in IDLE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding and controller state encoding.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } mdu_state_e;

   // Signed variants work on magnitudes and fix the sign afterwards.
   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Partial remainder stays below the divisor, so W+1 bits hold the
   // shifted value and the top bit of the difference is the borrow.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, dsr_i};
      qbit_o  = ~diff[WIDTH];
      rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle over WIDTH cycles. Defining MDU_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle combinational one.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;   // product high half / partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;   // multiplier shifting out / dividend -> quotient
   logic [WIDTH-1:0] dsr_q, dsr_d;   // multiplicand / divisor magnitude
   logic             neg_q, neg_d;   // negate product or quotient
   logic             rneg_q, rneg_d; // negate remainder
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;

   mdu_op_e          op_e;
   logic             accept, last, sgn;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] div_rem, quo_nxt;
   logic             div_qbit;

   function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   assign op_e   = mdu_op_e'(op);
   assign accept = start && !cancel && (state_q == IDLE || state_q == FIN);
   assign last   = (cnt_q == CW'(WIDTH - 1));
   assign sgn    = op_is_signed(op_e);
   assign mag_a  = fix_w(a, sgn & a[WIDTH-1]);
   assign mag_b  = fix_w(b, sgn & b[WIDTH-1]);

   // Shift-add multiply step: add multiplicand if the multiplier LSB is set,
   // then shift the {accumulator, multiplier} pair right by one.
   assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i  (rem_q),
      .bit_i  (quo_q[WIDTH-1]),
      .dsr_i  (dsr_q),
      .rem_o  (div_rem),
      .qbit_o (div_qbit)
   );

   assign quo_nxt = {quo_q[WIDTH-2:0], div_qbit};

   // Next-state, iteration datapath and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dsr_d   = dsr_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;

      case (state_q)
         MUL: begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d      = FIN;
               {hi_d, lo_d} = fix_2w({mul_sum[WIDTH:1], mul_sum[0], quo_q[WIDTH-1:1]}, neg_q);
            end
         end
         DIV: begin
            rem_d = div_rem;
            quo_d = quo_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d = FIN;
               lo_d    = fix_w(quo_nxt, neg_q);
               hi_d    = fix_w(div_rem, rneg_q);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = state_q;
      endcase

      if (accept) begin
         dbz_d  = 1'b0;
         cnt_d  = '0;
         rem_d  = '0;
         neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         rneg_d = sgn & a[WIDTH-1];
         if (op[1]) begin
            quo_d = mag_a;
            dsr_d = mag_b;
            if (b == '0) begin
               state_d = FIN;
               dbz_d   = 1'b1;
               hi_d    = a;
               lo_d    = '1;
            end else begin
               state_d = DIV;
            end
         end else begin
            quo_d = mag_b;
            dsr_d = mag_a;
`ifdef MDU_FAST_MUL_EN
            state_d      = FIN;
            {hi_d, lo_d} = fix_2w({{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b},
                                  sgn & (a[WIDTH-1] ^ b[WIDTH-1]));
`else
            state_d = MUL;
`endif
         end
      end

      // A flush abandons the operation and keeps the last delivered results.
      if (cancel) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dbz_d   = dbz_q;
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dsr_q   <= dsr_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy = (state_q == MUL) || (state_q == DIV);
   assign done = (state_q == FIN) && !cancel;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign dbz  = dbz_q;

endmodule
